// File: rtl/pong_ball_ctrl.sv
// =============================================================================
// Module   : pong_ball_ctrl
// Purpose  : Pong ball motion, paddle hit/miss detection, scoring and ball draw.
//            Optional macro PONG_BALL_HIDE_IDLE_EN blanks the ball outside RUN.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module pong_ball_ctrl #(
   parameter int c_GAME_WIDTH    = 40,
   parameter int c_GAME_HEIGHT   = 30,
   parameter int c_PADDLE_HEIGHT = 5,
   parameter int c_PADDLE_COL_P1 = 0,
   parameter int c_PADDLE_COL_P2 = 39,
   parameter int c_BALL_SPEED    = 1250000
) (
   input  logic       i_Clk,
   input  logic       i_Rst,
   input  logic       i_Game_Active,
   input  logic [5:0] i_Col_Count,
   input  logic [5:0] i_Row_Count,
   input  logic [5:0] i_Paddle_Y_P1,
   input  logic [5:0] i_Paddle_Y_P2,
   output logic       o_Draw_Ball,
   output logic [5:0] o_Ball_X,
   output logic [5:0] o_Ball_Y,
   output logic       o_P1_Score_Pulse,
   output logic       o_P2_Score_Pulse,
   output logic       o_Running
);

   localparam int               c_CNT_W      = (c_BALL_SPEED < 2) ? 1 : $clog2(c_BALL_SPEED + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_BALL_SPEED);
   localparam logic [5:0]       c_CENTRE_X   = 6'(c_GAME_WIDTH / 2);
   localparam logic [5:0]       c_CENTRE_Y   = 6'(c_GAME_HEIGHT / 2);
   localparam logic [5:0]       c_Y_MAX      = 6'(c_GAME_HEIGHT - 1);
   localparam logic [5:0]       c_P1_HIT_COL = 6'(c_PADDLE_COL_P1 + 1);
   localparam logic [5:0]       c_P2_HIT_COL = 6'(c_PADDLE_COL_P2 - 1);
   localparam logic [6:0]       c_PAD_SPAN   = 7'(c_PADDLE_HEIGHT);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t             state_q, state_d;
   logic [c_CNT_W-1:0] cnt_q, cnt_d;
   logic [5:0]         ball_x_q, ball_x_d;
   logic [5:0]         ball_y_q, ball_y_d;
   logic               dir_x_q, dir_x_d;
   logic               dir_y_q, dir_y_d;
   logic               draw_q, draw_d;
   logic               p1_pulse_q, p1_pulse_d;
   logic               p2_pulse_q, p2_pulse_d;

   logic [6:0] w_y7;
   logic [6:0] w_pad1_top, w_pad2_top;
   logic       w_hit_p1, w_hit_p2;

   // 7-bit compare so a paddle near the bottom cannot wrap its lower edge
   assign w_y7       = {1'b0, ball_y_q};
   assign w_pad1_top = {1'b0, i_Paddle_Y_P1};
   assign w_pad2_top = {1'b0, i_Paddle_Y_P2};
   assign w_hit_p1   = (w_pad1_top <= w_y7) && (w_y7 <= w_pad1_top + c_PAD_SPAN);
   assign w_hit_p2   = (w_pad2_top <= w_y7) && (w_y7 <= w_pad2_top + c_PAD_SPAN);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ball_x_d   = ball_x_q;
      ball_y_d   = ball_y_q;
      dir_x_d    = dir_x_q;
      dir_y_d    = dir_y_q;
      p1_pulse_d = 1'b0;
      p2_pulse_d = 1'b0;

      case (state_q)
         ST_IDLE: begin
            cnt_d    = '0;
            ball_x_d = c_CENTRE_X;
            ball_y_d = c_CENTRE_Y;
            if (i_Game_Active) begin
               state_d = ST_RUN;
            end
         end

         ST_RUN: begin
            if (!i_Game_Active) begin
               state_d  = ST_IDLE;
               cnt_d    = '0;
               ball_x_d = c_CENTRE_X;
               ball_y_d = c_CENTRE_Y;
            end else if (cnt_q == c_CNT_LAST) begin
               cnt_d = '0;

               if (dir_y_q) begin
                  if (ball_y_q == c_Y_MAX) begin
                     dir_y_d  = 1'b0;
                     ball_y_d = ball_y_q - 6'd1;
                  end else begin
                     ball_y_d = ball_y_q + 6'd1;
                  end
               end else begin
                  if (ball_y_q == 6'd0) begin
                     dir_y_d  = 1'b1;
                     ball_y_d = 6'd1;
                  end else begin
                     ball_y_d = ball_y_q - 6'd1;
                  end
               end

               // A miss overrides the vertical result: ball recentres, dir_y unchanged
               if (!dir_x_q && (ball_x_q == c_P1_HIT_COL)) begin
                  if (w_hit_p1) begin
                     dir_x_d  = 1'b1;
                     ball_x_d = ball_x_q + 6'd1;
                  end else begin
                     p2_pulse_d = 1'b1;
                     state_d    = ST_IDLE;
                     ball_x_d   = c_CENTRE_X;
                     ball_y_d   = c_CENTRE_Y;
                     dir_x_d    = 1'b0;
                     dir_y_d    = dir_y_q;
                  end
               end else if (dir_x_q && (ball_x_q == c_P2_HIT_COL)) begin
                  if (w_hit_p2) begin
                     dir_x_d  = 1'b0;
                     ball_x_d = ball_x_q - 6'd1;
                  end else begin
                     p1_pulse_d = 1'b1;
                     state_d    = ST_IDLE;
                     ball_x_d   = c_CENTRE_X;
                     ball_y_d   = c_CENTRE_Y;
                     dir_x_d    = 1'b1;
                     dir_y_d    = dir_y_q;
                  end
               end else if (dir_x_q) begin
                  ball_x_d = ball_x_q + 6'd1;
               end else begin
                  ball_x_d = ball_x_q - 6'd1;
               end
            end else begin
               cnt_d = cnt_q + c_CNT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
`ifdef PONG_BALL_HIDE_IDLE_EN
      draw_d = (state_q == ST_RUN) && (i_Col_Count == ball_x_q) && (i_Row_Count == ball_y_q);
`else
      draw_d = (i_Col_Count == ball_x_q) && (i_Row_Count == ball_y_q);
`endif
   end

   always_ff @(posedge i_Clk) begin
      if (i_Rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         ball_x_q   <= c_CENTRE_X;
         ball_y_q   <= c_CENTRE_Y;
         dir_x_q    <= 1'b1;
         dir_y_q    <= 1'b1;
         draw_q     <= 1'b0;
         p1_pulse_q <= 1'b0;
         p2_pulse_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ball_x_q   <= ball_x_d;
         ball_y_q   <= ball_y_d;
         dir_x_q    <= dir_x_d;
         dir_y_q    <= dir_y_d;
         draw_q     <= draw_d;
         p1_pulse_q <= p1_pulse_d;
         p2_pulse_q <= p2_pulse_d;
      end
   end

   assign o_Draw_Ball      = draw_q;
   assign o_Ball_X         = ball_x_q;
   assign o_Ball_Y         = ball_y_q;
   assign o_P1_Score_Pulse = p1_pulse_q;
   assign o_P2_Score_Pulse = p2_pulse_q;
   assign o_Running        = (state_q == ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_pong_ball_ctrl.sv
// =============================================================================
// Module   : tb_pong_ball_ctrl
// Purpose  : Directed self-checking bench for pong_ball_ctrl with c_BALL_SPEED=3.
// Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_pong_ball_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       active;
   logic [5:0] col, row, pad1, pad2;
   logic       draw, p1_pulse, p2_pulse, running;
   logic [5:0] bx, by;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   pong_ball_ctrl #(
      .c_GAME_WIDTH   (40),
      .c_GAME_HEIGHT  (30),
      .c_PADDLE_HEIGHT(5),
      .c_PADDLE_COL_P1(0),
      .c_PADDLE_COL_P2(39),
      .c_BALL_SPEED   (3)
   ) dut (
      .i_Clk           (clk),
      .i_Rst           (rst),
      .i_Game_Active   (active),
      .i_Col_Count     (col),
      .i_Row_Count     (row),
      .i_Paddle_Y_P1   (pad1),
      .i_Paddle_Y_P2   (pad2),
      .o_Draw_Ball     (draw),
      .o_Ball_X        (bx),
      .o_Ball_Y        (by),
      .o_P1_Score_Pulse(p1_pulse),
      .o_P2_Score_Pulse(p2_pulse),
      .o_Running       (running)
   );

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; active = 1'b0; col = 6'd20; row = 6'd15; pad1 = 6'd0; pad2 = 6'd0;
      tick(2);
      vectors++;
      if ({running, p1_pulse, p2_pulse, draw, bx, by} !== {1'b0, 1'b0, 1'b0, 1'b0, 6'd20, 6'd15}) begin
         miscompares++;
         $display("FAIL reset: run/p1/p2/draw/x/y=%b/%b/%b/%b/%0d/%0d want 0/0/0/0/20/15",
                  running, p1_pulse, p2_pulse, draw, bx, by);
      end
      rst = 1'b0;
   endtask

   task automatic test_idle_draw;
      logic exp_draw;
`ifdef PONG_BALL_HIDE_IDLE_EN
      exp_draw = 1'b0;
`else
      exp_draw = 1'b1;
`endif
      tick(1);
      vectors++;
      if (draw !== exp_draw) begin
         miscompares++;
         $display("FAIL idle_draw_hit: draw=%b want %b", draw, exp_draw);
      end
      col = 6'd21;
      tick(1);
      vectors++;
      if (draw !== 1'b0) begin
         miscompares++;
         $display("FAIL idle_draw_off: draw=%b want 0", draw);
      end
   endtask

   task automatic test_start_and_step;
      active = 1'b1;
      tick(1);
      vectors++;
      if ({running, bx, by} !== {1'b1, 6'd20, 6'd15}) begin
         miscompares++;
         $display("FAIL start: run/x/y=%b/%0d/%0d want 1/20/15", running, bx, by);
      end
      tick(3);
      vectors++;
      if ({bx, by} !== {6'd20, 6'd15}) begin
         miscompares++;
         $display("FAIL pre_step: x/y=%0d/%0d want 20/15", bx, by);
      end
      tick(1);
      vectors++;
      if ({bx, by} !== {6'd21, 6'd16}) begin
         miscompares++;
         $display("FAIL first_step: x/y=%0d/%0d want 21/16", bx, by);
      end
   endtask

   task automatic test_bottom_bounce;
      tick(4 * 13);
      vectors++;
      if ({bx, by} !== {6'd34, 6'd29}) begin
         miscompares++;
         $display("FAIL at_bottom: x/y=%0d/%0d want 34/29", bx, by);
      end
      tick(4);
      vectors++;
      if ({bx, by} !== {6'd35, 6'd28}) begin
         miscompares++;
         $display("FAIL bottom_bounce: x/y=%0d/%0d want 35/28", bx, by);
      end
      tick(4);
      vectors++;
      if ({bx, by} !== {6'd36, 6'd27}) begin
         miscompares++;
         $display("FAIL after_bounce: x/y=%0d/%0d want 36/27", bx, by);
      end
   endtask

   task automatic test_right_hit;
      pad2 = 6'd20;   // covers rows 20..25; ball arrives at row 25
      tick(4 * 2);
      vectors++;
      if ({bx, by} !== {6'd38, 6'd25}) begin
         miscompares++;
         $display("FAIL at_right: x/y=%0d/%0d want 38/25", bx, by);
      end
      tick(4);
      vectors++;
      if ({running, p1_pulse, p2_pulse, bx, by} !== {1'b1, 1'b0, 1'b0, 6'd37, 6'd24}) begin
         miscompares++;
         $display("FAIL right_hit: run/p1/p2/x/y=%b/%b/%b/%0d/%0d want 1/0/0/37/24",
                  running, p1_pulse, p2_pulse, bx, by);
      end
   endtask

   task automatic test_top_bounce;
      tick(4 * 24);
      vectors++;
      if ({bx, by} !== {6'd13, 6'd0}) begin
         miscompares++;
         $display("FAIL at_top: x/y=%0d/%0d want 13/0", bx, by);
      end
      tick(4);
      vectors++;
      if ({bx, by} !== {6'd12, 6'd1}) begin
         miscompares++;
         $display("FAIL top_bounce: x/y=%0d/%0d want 12/1", bx, by);
      end
   endtask

   task automatic test_left_miss;
      pad1 = 6'd6;    // covers rows 6..11; ball arrives at row 12
      tick(4 * 11);
      vectors++;
      if ({bx, by} !== {6'd1, 6'd12}) begin
         miscompares++;
         $display("FAIL at_left: x/y=%0d/%0d want 1/12", bx, by);
      end
      tick(4);
      vectors++;
      if ({running, p1_pulse, p2_pulse, bx, by} !== {1'b0, 1'b0, 1'b1, 6'd20, 6'd15}) begin
         miscompares++;
         $display("FAIL left_miss: run/p1/p2/x/y=%b/%b/%b/%0d/%0d want 0/0/1/20/15",
                  running, p1_pulse, p2_pulse, bx, by);
      end
      tick(1);
      vectors++;
      if ({running, p1_pulse, p2_pulse} !== {1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL left_miss_pulse_end: run/p1/p2=%b/%b/%b want 1/0/0", running, p1_pulse, p2_pulse);
      end
   endtask

   task automatic test_left_hit;
      pad1 = 6'd24;   // covers rows 24..29; ball arrives at row 24
      tick(4 * 14);
      vectors++;
      if ({bx, by} !== {6'd6, 6'd29}) begin
         miscompares++;
         $display("FAIL serve_left: x/y=%0d/%0d want 6/29", bx, by);
      end
      tick(4 * 5);
      vectors++;
      if ({bx, by} !== {6'd1, 6'd24}) begin
         miscompares++;
         $display("FAIL at_left2: x/y=%0d/%0d want 1/24", bx, by);
      end
      tick(4);
      vectors++;
      if ({running, p1_pulse, p2_pulse, bx, by} !== {1'b1, 1'b0, 1'b0, 6'd2, 6'd23}) begin
         miscompares++;
         $display("FAIL left_hit: run/p1/p2/x/y=%b/%b/%b/%0d/%0d want 1/0/0/2/23",
                  running, p1_pulse, p2_pulse, bx, by);
      end
   endtask

   task automatic test_right_miss;
      pad2 = 6'd14;   // covers rows 14..19; ball arrives at row 13
      tick(4 * 23);
      vectors++;
      if ({bx, by} !== {6'd25, 6'd0}) begin
         miscompares++;
         $display("FAIL at_top2: x/y=%0d/%0d want 25/0", bx, by);
      end
      tick(4 * 13);
      vectors++;
      if ({bx, by} !== {6'd38, 6'd13}) begin
         miscompares++;
         $display("FAIL at_right2: x/y=%0d/%0d want 38/13", bx, by);
      end
      tick(4);
      vectors++;
      if ({running, p1_pulse, p2_pulse, bx, by} !== {1'b0, 1'b1, 1'b0, 6'd20, 6'd15}) begin
         miscompares++;
         $display("FAIL right_miss: run/p1/p2/x/y=%b/%b/%b/%0d/%0d want 0/1/0/20/15",
                  running, p1_pulse, p2_pulse, bx, by);
      end
      tick(1);
      vectors++;
      if ({running, p1_pulse, p2_pulse} !== {1'b1, 1'b0, 1'b0}) begin
         miscompares++;
         $display("FAIL right_miss_pulse_end: run/p1/p2=%b/%b/%b want 1/0/0", running, p1_pulse, p2_pulse);
      end
   endtask

   task automatic test_run_draw;
      tick(4);
      vectors++;
      if ({bx, by} !== {6'd21, 6'd16}) begin
         miscompares++;
         $display("FAIL serve_right: x/y=%0d/%0d want 21/16", bx, by);
      end
      col = 6'd21; row = 6'd16;
      tick(1);
      vectors++;
      if (draw !== 1'b1) begin
         miscompares++;
         $display("FAIL run_draw_hit: draw=%b want 1", draw);
      end
      row = 6'd15;
      tick(1);
      vectors++;
      if (draw !== 1'b0) begin
         miscompares++;
         $display("FAIL run_draw_off: draw=%b want 0", draw);
      end
   endtask

   task automatic test_deactivate;
      // Two clocks into the step period; one more brings the counter to its terminal value
      tick(1);
      active = 1'b0;
      tick(1);
      vectors++;
      if ({running, p1_pulse, p2_pulse, bx, by} !== {1'b0, 1'b0, 1'b0, 6'd20, 6'd15}) begin
         miscompares++;
         $display("FAIL deactivate: run/p1/p2/x/y=%b/%b/%b/%0d/%0d want 0/0/0/20/15",
                  running, p1_pulse, p2_pulse, bx, by);
      end
      tick(5);
      vectors++;
      if ({running, bx, by} !== {1'b0, 6'd20, 6'd15}) begin
         miscompares++;
         $display("FAIL idle_hold: run/x/y=%b/%0d/%0d want 0/20/15", running, bx, by);
      end
   endtask

   task automatic test_reset_on_step;
      pad2 = 6'd0;    // covers rows 0..5; ball will miss at row 25
      active = 1'b1;
      tick(1);
      tick(4 * 18);
      vectors++;
      if ({running, bx, by} !== {1'b1, 6'd38, 6'd25}) begin
         miscompares++;
         $display("FAIL at_right3: run/x/y=%b/%0d/%0d want 1/38/25", running, bx, by);
      end
      tick(3);
      rst = 1'b1;
      tick(1);
      vectors++;
      if ({running, p1_pulse, p2_pulse, bx, by} !== {1'b0, 1'b0, 1'b0, 6'd20, 6'd15}) begin
         miscompares++;
         $display("FAIL reset_on_step: run/p1/p2/x/y=%b/%b/%b/%0d/%0d want 0/0/0/20/15",
                  running, p1_pulse, p2_pulse, bx, by);
      end
      tick(1);
      rst = 1'b0;
      vectors++;
      if ({p1_pulse, p2_pulse} !== 2'b00) begin
         miscompares++;
         $display("FAIL reset_no_pulse: p1/p2=%b/%b want 0/0", p1_pulse, p2_pulse);
      end
      // Directions were (right, up) before reset; reset restores (right, down)
      tick(1);
      tick(4);
      vectors++;
      if ({running, bx, by} !== {1'b1, 6'd21, 6'd16}) begin
         miscompares++;
         $display("FAIL reset_dirs: run/x/y=%b/%0d/%0d want 1/21/16", running, bx, by);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_idle_draw();
      test_start_and_step();
      test_bottom_bounce();
      test_right_hit();
      test_top_bounce();
      test_left_miss();
      test_left_hit();
      test_right_miss();
      test_run_draw();
      test_deactivate();
      test_reset_on_step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire
